// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable, data enable,
// frame-start pulse and a line-prefetch request for the SDRAM line reader.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PREFETCH = 8,
    parameter int CW       = 10
) (
    input  logic          vga_clk,
    input  logic          Reset,
    input  logic          en,
    output logic          hs,
    output logic          vs,
    output logic          h_blank,
    output logic          v_blank,
    output logic          de,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          frame_start,
    output logic          line_fetch_req,
    output logic [CW-1:0] fetch_line
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] REQ_X    = CW'(H_TOTAL - PREFETCH);

    logic [CW-1:0] hc, vc;
    logic [CW-1:0] hc_nxt, vc_nxt, line_nxt;
    logic          hs_nxt, vs_nxt, fs_nxt, req_nxt;

    // Registered outputs are derived from the next counter values so they
    // land in the same cycle as the DrawX/DrawY they describe.
    always_comb begin
        hc_nxt = hc + CW'(1);
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + CW'(1);
        end
        hs_nxt   = (hc_nxt >= HS_FIRST && hc_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
        vs_nxt   = (vc_nxt >= VS_FIRST && vc_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
        fs_nxt   = (hc_nxt == '0) && (vc_nxt == '0);
        line_nxt = (vc_nxt == V_LAST) ? '0 : vc_nxt + CW'(1);
        req_nxt  = (hc_nxt == REQ_X) && (line_nxt < V_ACT);
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            hc             <= '0;
            vc             <= '0;
            hs             <= ~HS_POL;
            vs             <= ~VS_POL;
            frame_start    <= 1'b1;
            line_fetch_req <= 1'b0;
            fetch_line     <= '0;
        end else if (en) begin
            hc             <= hc_nxt;
            vc             <= vc_nxt;
            hs             <= hs_nxt;
            vs             <= vs_nxt;
            frame_start    <= fs_nxt;
            line_fetch_req <= req_nxt;
            if (req_nxt)
                fetch_line <= line_nxt;
        end
    end

    always_comb begin
        h_blank = (hc >= H_ACT);
        v_blank = (vc >= V_ACT);
        de      = ~h_blank & ~v_blank;
    end

    assign DrawX = hc;
    assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a raster-position model predicts every
// output per clock; a monitor compares the DUT against the queued predictions.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam bit HP = 1'b1, VP = 1'b1;
    localparam int PF = 2;
    localparam int CW = 5;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic          vga_clk = 1'b0;
    logic          Reset;
    logic          en;
    logic          hs, vs, h_blank, v_blank, de, frame_start, line_fetch_req;
    logic [CW-1:0] DrawX, DrawY, fetch_line;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .PREFETCH(PF), .CW(CW)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset), .en(en),
        .hs(hs), .vs(vs), .h_blank(h_blank), .v_blank(v_blank), .de(de),
        .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .line_fetch_req(line_fetch_req), .fetch_line(fetch_line)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int x, y, hs, vs, hb, vb, de, fs, req, fl;
        bit fl_chk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   req_seen = 0;

    // Expected outputs for a raster position taken as a flat pixel index.
    function automatic exp_t model(int pos, bit in_rst);
        exp_t e;
        int   n;
        e.x   = pos % HT;
        e.y   = pos / HT;
        e.hs  = (e.x >= HA + HF && e.x < HA + HF + HSW) ? int'(HP) : int'(!HP);
        e.vs  = (e.y >= VA + VF && e.y < VA + VF + VSW) ? int'(VP) : int'(!VP);
        e.hb  = (e.x >= HA) ? 1 : 0;
        e.vb  = (e.y >= VA) ? 1 : 0;
        e.de  = (e.hb == 0 && e.vb == 0) ? 1 : 0;
        e.fs  = (pos == 0) ? 1 : 0;
        n     = (e.y + 1) % VT;
        e.req = (!in_rst && e.x == HT - PF && n < VA) ? 1 : 0;
        e.fl  = in_rst ? 0 : n;
        e.fl_chk = in_rst || (e.req == 1);
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("DrawX", int'(DrawX), e.x);
                chk("DrawY", int'(DrawY), e.y);
                chk("hs", int'(hs), e.hs);
                chk("vs", int'(vs), e.vs);
                chk("h_blank", int'(h_blank), e.hb);
                chk("v_blank", int'(v_blank), e.vb);
                chk("de", int'(de), e.de);
                chk("frame_start", int'(frame_start), e.fs);
                chk("line_fetch_req", int'(line_fetch_req), e.req);
                if (e.fl_chk)
                    chk("fetch_line", int'(fetch_line), e.fl);
                if (line_fetch_req)
                    req_seen++;
            end
        end
    end

    initial begin : driver
        int pos;
        bit r, e, did_rst;
        int req_before;
        pos     = 0;
        did_rst = 0;
        Reset   = 1'b1;
        en      = 1'b0;
        q.push_back(model(0, 1'b1));
        req_before = 0;
        for (int i = 0; i < 2300; i++) begin
            @(posedge vga_clk);
            #2;
            if (i < 3) begin
                r = 1'b1; e = 1'b1;
            end else if (i < 3 + 2 * FT) begin
                r = 1'b0; e = 1'b1;
            end else if (i < 3 + 2 * FT + 4 * FT) begin
                r = 1'b0; e = (i % 4 == 0);
            end else if (i < 3 + 2 * FT + 4 * FT + 120) begin
                e = 1'b1;
                r = (pos == 3 * HT + 5) && !did_rst;
                if (r) did_rst = 1'b1;
            end else begin
                e = ($urandom_range(0, 2) != 0);
                r = ($urandom_range(0, 299) == 0);
            end
            // Two full frames at en=1 must yield exactly 2*(VA) requests.
            if (i == 3)
                req_before = req_seen;
            if (i == 3 + 2 * FT)
                chk("req_count_2frames", req_seen - req_before, 2 * VA);
            Reset = r;
            en    = e;
            if (r)
                pos = 0;
            else if (e)
                pos = (pos + 1) % FT;
            q.push_back(model(pos, r));
        end
        @(posedge vga_clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        chk("mid_frame_reset_hit", int'(did_rst), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
